pending_index_issuer: RTL

- Upstream stage of the priority encoder.
- Collects single-cycle request pulses into a sticky pending vector and selects the lowest-index pending bit.
- Issues the selected index over a valid/ready handshake and clears that bit once it is accepted.
- Downstream consumers see one index per handshake, in priority order (bit 0 highest).

---
 rtl/pending_index_issuer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pending_index_issuer.sv
// Sticky request collector that issues the lowest pending index over valid/ready.
// Optional self-checks are compiled in with `define PENDING_ISSUER_ASSERT_EN.
module pending_index_issuer #(
    parameter int unsigned INPUT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INPUT_WIDTH-1:0]         req_bits,
    output logic [INPUT_WIDTH-1:0]         pending,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(INPUT_WIDTH)-1:0] out_index,
    output logic                           overflow,
    input  logic                           overflow_clr
);

    localparam int unsigned IDX_W = $clog2(INPUT_WIDTH);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                 state, state_n;
    logic                   hs;
    logic [INPUT_WIDTH-1:0] idx_onehot;
    logic [INPUT_WIDTH-1:0] clr_mask;
    logic [INPUT_WIDTH-1:0] hold_mask;
    logic [INPUT_WIDTH-1:0] cand;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       index_n;
    logic [INPUT_WIDTH-1:0] pending_n;
    logic                   overflow_n;

    assign out_valid = (state == HOLD);
    assign hs        = out_valid & out_ready;

    always_comb begin
        idx_onehot = '0;
        for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
            idx_onehot[i] = (out_index == IDX_W'(i));
        end
        clr_mask  = hs ? idx_onehot : '0;
        hold_mask = (out_valid & ~hs) ? idx_onehot : '0;
        cand      = pending & ~clr_mask & ~hold_mask;

        // Scan downwards so the last hit left in sel is the lowest index.
        sel = '0;
        for (int unsigned i = INPUT_WIDTH; i > 0; i--) begin
            if (cand[i-1]) begin
                sel = IDX_W'(i - 1);
            end
        end

        pending_n  = (pending & ~clr_mask) | req_bits;
        overflow_n = (|(req_bits & pending & ~clr_mask)) | (overflow & ~overflow_clr);

        state_n = state;
        index_n = out_index;
        if (state == EMPTY || hs) begin
            if (|cand) begin
                state_n = HOLD;
                index_n = sel;
            end else begin
                state_n = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_index <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            out_index <= index_n;
            pending   <= pending_n;
            overflow  <= overflow_n;
        end
    end

`ifdef PENDING_ISSUER_ASSERT_EN
    logic                   stall_q;
    logic                   empty_q;
    logic [IDX_W-1:0]       index_q;
    logic [INPUT_WIDTH-1:0] below_sel;

    always_comb begin
        below_sel = '0;
        for (int unsigned i = 0; i < INPUT_WIDTH; i++) begin
            below_sel[i] = (IDX_W'(i) < sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
            empty_q <= 1'b0;
            index_q <= '0;
        end else begin
            stall_q <= out_valid & ~out_ready;
            empty_q <= (pending == '0);
            index_q <= out_index;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                assert (32'(out_index) < INPUT_WIDTH);
                assert (pending[out_index]);
            end
            if ((state == EMPTY || hs) && (|cand)) begin
                assert ((cand & below_sel) == '0);
            end
            if (stall_q) begin
                assert (out_valid && out_index == index_q);
            end
            if (empty_q) begin
                assert (!out_valid);
            end
        end
    end
`endif

endmodule
